instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
Fetch stage that sits directly upstream of the single-cycle R-type datapath. It supplies the 32-bit instruction word that the datapath decodes (op [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0]).
- Owns the program counter.
- Issues requests to the instruction memory over a req/ack handshake that tolerates variable latency.
- Holds each fetched word in an output register until decode accepts it.
- Supports redirect (branch/jump) with squash of in-flight fetches.

Parameters:
ADDR_W, 8, PC / instruction-memory byte-address width (matches 8-bit instruction address).
RESET_PC, 0, PC value loaded on reset.
PC_STEP, 4, byte increment per sequential fetch.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  ADDR_W  fetch byte address; stable while imem_req=1.
imem_ack  in  1  memory returns data this cycle.
imem_rdata  in  32  instruction word; valid when imem_ack=1.
redirect  in  1  one-cycle pulse: refetch from redirect_pc.
redirect_pc  in  ADDR_W  redirect target; bits [1:0] are forced to 0.
if_instr  out  32  instruction to decode.
if_pc  out  ADDR_W  address of if_instr.
if_valid  out  1  if_instr/if_pc are valid.
id_ready  in  1  decode accepts; a transfer occurs when if_valid&&id_ready.
fetch_cnt  out  CNT_W  instructions delivered (saturating).
squash_cnt  out  CNT_W  memory responses discarded (saturating).

Behaviour:
- Reset (sync, dominates all other inputs, including a same-cycle imem_ack):
  - state=IDLE, pc=RESET_PC.
  - if_valid=0, if_instr=0, if_pc=0.
  - fetch_cnt=0, squash_cnt=0.
  - imem_req=0, imem_addr=RESET_PC.
  - An outstanding request is abandoned; its late ack is ignored.
- imem_req=1 exactly in states WAIT_ACK and DRAIN (decoded from registered state).
- imem_addr=pc in WAIT_ACK. In DRAIN it holds the address of the abandoned request (held in register old_addr).
- Handshake rule: once imem_req rises it is never withdrawn, and imem_addr never changes, until imem_ack. Ack may arrive in the same cycle req rises (0-wait memory).
- States and transitions (redirect has priority over all normal transitions):
  - IDLE → WAIT_ACK (unconditional, one cycle after reset released).
  - WAIT_ACK, imem_ack && !redirect → FULL:
    - if_instr<=imem_rdata, if_pc<=pc, if_valid<=1.
    - pc<=pc+PC_STEP, mod 2^ADDR_W (wraps to 0).
  - WAIT_ACK, redirect && imem_ack → WAIT_ACK:
    - pc<=redirect_pc&~3.
    - Data discarded; squash_cnt++.
  - WAIT_ACK, redirect && !imem_ack → DRAIN:
    - old_addr<=pc, pc<=redirect_pc&~3.
  - FULL, if_valid && id_ready → WAIT_ACK: if_valid<=0, fetch_cnt++.
  - FULL, !id_ready → stay; if_instr/if_pc held stable (no change while stalled).
  - FULL, redirect → WAIT_ACK:
    - pc<=redirect_pc&~3, if_valid<=0.
    - A same-cycle transfer (id_ready=1) still counts in fetch_cnt.
  - DRAIN, imem_ack → WAIT_ACK: data discarded, squash_cnt++.
  - DRAIN, redirect (with or without ack) → pc<=new target. Stay in DRAIN if no ack; go to WAIT_ACK if ack (squash_cnt++).
- Throughput: 1 instruction per 2 cycles with a 0-wait memory and decode always ready; latency reset-release → first if_valid = 2 cycles.
- Counters saturate at 2^CNT_W−1; no wrap.
- if_valid never asserts for data returned for a squashed address.

Test Plan:
- Sequential fetch: reset 2 cycles; 0-wait memory returning {0x00221820, 0x00832022, 0x00A53024}; id_ready=1 → if_pc 0x00, 0x04, 0x08 on every other cycle, if_instr matches, fetch_cnt=3, squash_cnt=0.
- Stall: imem_ack 3 cycles late, id_ready=0 for 4 cycles once valid → imem_addr stable during wait; if_instr/if_pc held while stalled; exactly one transfer; next imem_addr=0x04.
- Redirect in flight: redirect_pc=0x23 asserted while WAIT_ACK at pc=0x10 with no ack:
  - DRAIN keeps imem_addr=0x10 until ack.
  - That data never appears; squash_cnt=1.
  - Next request has imem_addr=0x20, and if_pc=0x20.
- Redirect with same-cycle ack, and redirect in FULL while id_ready=1:
  - The ack case gives squash_cnt=1.
  - The FULL case gives fetch_cnt incremented once and the new fetch at the target.
- Wrap and saturation:
  - Redirect to 0xFC → after that word is delivered, next imem_addr=0x00.
  - Preload fetch_cnt near max (CNT_W=4, 20 transfers) → fetch_cnt holds 15.
- Reset mid-operation: assert reset in DRAIN with imem_ack same cycle → next cycle state IDLE, if_valid=0, imem_req=0, counters 0, squash_cnt not incremented.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage feeding the single-cycle R-type datapath.
// Owns the PC, fetches 32-bit words over a variable-latency req/ack
// handshake, holds each word until decode accepts it, and handles
// redirects by squashing any fetch still in flight.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   imem_req, imem_addr     fetch request / byte address to instruction memory
//   imem_ack, imem_rdata    memory response strobe / instruction word
//   redirect, redirect_pc   one-cycle refetch pulse and its target
//   if_instr, if_pc         instruction and its address toward decode
//   if_valid, id_ready      output handshake with decode
//   fetch_cnt, squash_cnt   saturating delivered / discarded counters
module instr_fetch_stage #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    input  logic              id_ready,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  squash_cnt
);

    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MSK = ~ADDR_W'(3);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        FULL     = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] old_addr;
    logic [ADDR_W-1:0] target;

    // Redirect targets are forced word-aligned.
    assign target = redirect_pc & ALIGN_MSK;

    // DRAIN keeps presenting the abandoned address so the handshake stays
    // stable until memory answers it.
    assign imem_req  = (state == WAIT_ACK) || (state == DRAIN);
    assign imem_addr = (state == DRAIN) ? old_addr : pc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    // Fetch control; redirect takes priority over normal transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            old_addr   <= RESET_PC;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            fetch_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= WAIT_ACK;
                    if (redirect) begin
                        pc <= target;
                    end
                end
                WAIT_ACK: begin
                    if (redirect) begin
                        pc <= target;
                        if (imem_ack) begin
                            squash_cnt <= sat_inc(squash_cnt);
                        end else begin
                            // Request already on the bus must be seen through.
                            old_addr <= pc;
                            state    <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc + STEP;
                        state    <= FULL;
                    end
                end
                FULL: begin
                    // A transfer in the redirect cycle still counts.
                    if (id_ready) begin
                        fetch_cnt <= sat_inc(fetch_cnt);
                    end
                    if (redirect) begin
                        pc       <= target;
                        if_valid <= 1'b0;
                        state    <= WAIT_ACK;
                    end else if (id_ready) begin
                        if_valid <= 1'b0;
                        state    <= WAIT_ACK;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    if (imem_ack) begin
                        squash_cnt <= sat_inc(squash_cnt);
                        state      <= WAIT_ACK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: expected deliveries are queued
// by the stimulus and checked by a monitor on every decode transfer.
module tb_instr_fetch_stage;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              if_valid;
    logic              id_ready;
    logic [CNT_W-1:0]  fetch_cnt;
    logic [CNT_W-1:0]  squash_cnt;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       instr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    logic manual;
    int   mem_lat;
    int   wcnt;
    int   k;

    always #5 clk = ~clk;

    instr_fetch_stage #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(8'h00),
        .PC_STEP (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .id_ready   (id_ready),
        .fetch_cnt  (fetch_cnt),
        .squash_cnt (squash_cnt)
    );

    function automatic logic [31:0] word_at(input logic [7:0] a);
        case (a)
            8'h00:   return 32'h00221820;
            8'h04:   return 32'h00832022;
            8'h08:   return 32'h00A53024;
            default: return {8'h5A, a, ~a, 8'h20};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        id_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_fc(input logic [CNT_W-1:0] v, input int lim, input string name);
        int n = 0;
        while (fetch_cnt != v && n < lim) begin
            tick();
            n++;
        end
        chk(name, 32'(fetch_cnt), 32'(v));
    endtask

    task automatic wait_q_empty(input int lim, input string name);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            tick();
            n++;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic push(input logic [7:0] a);
        sb.push_back('{pc: a, instr: word_at(a)});
    endtask

    // Memory model: answers after mem_lat waiting cycles unless the
    // stimulus has taken manual control of ack/rdata.
    always begin
        @(posedge clk);
        #2;
        if (!manual) begin
            if (reset || !imem_req) begin
                imem_ack = 1'b0;
                wcnt     = 0;
            end else if (wcnt >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = word_at(imem_addr);
                wcnt       = 0;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    // Monitor: every decode transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && if_valid && id_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_xfer: actual pc 0x%0h instr 0x%0h, required no transfer",
                         if_pc, if_instr);
            end else begin
                e = sb.pop_front();
                chk("xfer_pc", 32'(if_pc), 32'(e.pc));
                chk("xfer_instr", if_instr, e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual still running, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        manual      = 1'b0;
        mem_lat     = 0;
        wcnt        = 0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", 32'(if_pc), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
        chk("rst_squash_cnt", 32'(squash_cnt), 32'd0);

        // Sequential fetch, 0-wait memory, decode always ready
        push(8'h00);
        push(8'h04);
        push(8'h08);
        id_ready = 1'b1;
        reset    = 1'b0;
        k = 0;
        while (fetch_cnt != 4'd3 && k < 30) begin
            tick();
            k++;
        end
        id_ready = 1'b0;
        chk("seq_cycles", 32'(k), 32'd7);
        chk("seq_fetch_cnt", 32'(fetch_cnt), 32'd3);
        chk("seq_squash_cnt", 32'(squash_cnt), 32'd0);
        chk("seq_q_empty", 32'(sb.size()), 32'd0);

        // Late ack and decode stall
        mem_lat = 3;
        do_reset();
        push(8'h00);
        k = 0;
        tick();
        while (!if_valid && k < 10) begin
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_addr", 32'(imem_addr), 32'd0);
            tick();
            k++;
        end
        chk("stall_wait_cycles", 32'(k), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_if_pc", 32'(if_pc), 32'd0);
            chk("stall_if_instr", if_instr, 32'h00221820);
            tick();
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("stall_fetch_cnt", 32'(fetch_cnt), 32'd1);
        chk("stall_next_req", 32'(imem_req), 32'd1);
        chk("stall_next_addr", 32'(imem_addr), 32'h04);
        repeat (8) tick();
        chk("stall_one_xfer", 32'(fetch_cnt), 32'd1);
        chk("stall_q_empty", 32'(sb.size()), 32'd0);

        // Redirect while a request is in flight
        mem_lat = 0;
        do_reset();
        push(8'h00);
        push(8'h04);
        push(8'h08);
        push(8'h0C);
        id_ready = 1'b1;
        wait_fc(4'd4, 30, "rif_prefetch");
        manual      = 1'b1;
        imem_ack    = 1'b0;
        chk("rif_addr_before", 32'(imem_addr), 32'h10);
        redirect    = 1'b1;
        redirect_pc = 8'h23;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_req", 32'(imem_req), 32'd1);
            chk("drain_addr", 32'(imem_addr), 32'h10);
            chk("drain_valid", 32'(if_valid), 32'd0);
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        tick();
        imem_ack = 1'b0;
        chk("rif_squash_cnt", 32'(squash_cnt), 32'd1);
        chk("rif_new_addr", 32'(imem_addr), 32'h20);
        chk("rif_new_req", 32'(imem_req), 32'd1);
        chk("rif_valid", 32'(if_valid), 32'd0);
        push(8'h20);
        manual = 1'b0;
        wait_fc(4'd5, 10, "rif_target_xfer");
        id_ready = 1'b0;
        wait_q_empty(10, "rif_q_empty");

        // Redirect with same-cycle ack, then redirect in FULL with transfer
        manual   = 1'b1;
        imem_ack = 1'b0;
        do_reset();
        tick();
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        imem_ack    = 1'b1;
        imem_rdata  = 32'hBAD0BAD0;
        tick();
        redirect = 1'b0;
        imem_ack = 1'b0;
        chk("rack_squash_cnt", 32'(squash_cnt), 32'd1);
        chk("rack_addr", 32'(imem_addr), 32'h40);
        chk("rack_valid", 32'(if_valid), 32'd0);
        push(8'h40);
        manual = 1'b0;
        tick();
        chk("rfull_valid", 32'(if_valid), 32'd1);
        chk("rfull_if_pc", 32'(if_pc), 32'h40);
        redirect    = 1'b1;
        redirect_pc = 8'h81;
        id_ready    = 1'b1;
        tick();
        redirect = 1'b0;
        chk("rfull_fetch_cnt", 32'(fetch_cnt), 32'd1);
        chk("rfull_addr", 32'(imem_addr), 32'h80);
        chk("rfull_valid_drop", 32'(if_valid), 32'd0);
        push(8'h80);
        wait_fc(4'd2, 10, "rfull_target_xfer");
        id_ready = 1'b0;
        chk("rfull_squash_cnt", 32'(squash_cnt), 32'd1);
        wait_q_empty(10, "rfull_q_empty");

        // Address wrap and fetch counter saturation
        manual   = 1'b1;
        imem_ack = 1'b0;
        do_reset();
        tick();
        redirect    = 1'b1;
        redirect_pc = 8'hFC;
        imem_ack    = 1'b1;
        imem_rdata  = 32'h0;
        tick();
        redirect = 1'b0;
        imem_ack = 1'b0;
        manual   = 1'b0;
        push(8'hFC);
        for (int i = 0; i < 19; i++) begin
            push(8'(i * 4));
        end
        id_ready = 1'b1;
        wait_fc(4'd1, 10, "wrap_first_xfer");
        chk("wrap_addr", 32'(imem_addr), 32'h00);
        wait_q_empty(100, "sat_q_empty");
        id_ready = 1'b0;
        chk("sat_fetch_cnt", 32'(fetch_cnt), 32'd15);

        // Reset in DRAIN with a same-cycle ack
        manual   = 1'b1;
        imem_ack = 1'b0;
        do_reset();
        tick();
        redirect    = 1'b1;
        redirect_pc = 8'h30;
        imem_ack    = 1'b1;
        imem_rdata  = 32'h0;
        tick();
        imem_ack    = 1'b0;
        redirect_pc = 8'h60;
        tick();
        redirect = 1'b0;
        chk("mid_squash_pre", 32'(squash_cnt), 32'd1);
        chk("mid_drain_addr", 32'(imem_addr), 32'h30);
        chk("mid_drain_req", 32'(imem_req), 32'd1);
        reset    = 1'b1;
        imem_ack = 1'b1;
        tick();
        chk("mid_valid", 32'(if_valid), 32'd0);
        chk("mid_req", 32'(imem_req), 32'd0);
        chk("mid_addr", 32'(imem_addr), 32'h00);
        chk("mid_squash_cnt", 32'(squash_cnt), 32'd0);
        chk("mid_fetch_cnt", 32'(fetch_cnt), 32'd0);
        reset    = 1'b0;
        imem_ack = 1'b0;
        tick();
        chk("mid_restart_req", 32'(imem_req), 32'd1);
        chk("mid_restart_addr", 32'(imem_addr), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
